pwm_cfg_arbiter: RTL and testbench

- Shares the PWM peripheral's five 8-bit configuration registers between two write requesters: req0, the SPI transaction decoder, and req1, the boot/preload sequencer.
- Arbitrates round-robin, accepts at most one command per cycle and registers it into a commit stage.
- Owns the register bank that drives the PWM peripheral directly.
- Stages the duty cycle in a shadow register so it only changes on a PWM frame boundary.

---
 rtl/pwm_cfg_arbiter.sv | 141 ++++++++++++++
 tb/tb_pwm_cfg_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pwm_cfg_arbiter.sv
// Round-robin arbiter that shares the PWM configuration bank between the SPI decoder (req0)
// and the preload sequencer (req1). Writes pass through one commit stage before reaching the bank.
module pwm_cfg_arbiter #(
  parameter int NUM_REGS    = 5,
  parameter bit SHADOW_DUTY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  input  logic       frame_sync,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       duty_pending,
  output logic [7:0] err_count,
  output logic       wr_strobe
);

  localparam logic [6:0] LP_NUM_REGS  = 7'(NUM_REGS);
  localparam logic [6:0] LP_DUTY_ADDR = 7'd4;

  logic       r_rr;
  logic       r_c_valid;
  logic [6:0] r_c_addr;
  logic [7:0] r_c_data;
  logic [7:0] r_bank [0:3];
  logic [7:0] r_duty;
  logic       r_pending;
  logic [7:0] r_err;
  logic       r_strobe;

  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_wr_ok;
  logic       w_wr_bad;
  logic       w_duty_wr;

  // r_rr == 0 gives req0 priority when both requesters are valid.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      w_gnt0 = req0_valid && (!req1_valid || !r_rr);
      w_gnt1 = req1_valid && (!req0_valid ||  r_rr);
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr      <= 1'b0;
      r_c_valid <= 1'b0;
      r_c_addr  <= '0;
      r_c_data  <= '0;
    end else begin
      r_c_valid <= w_gnt0 || w_gnt1;
      if (w_gnt0) begin
        r_rr     <= 1'b1;
        r_c_addr <= req0_addr;
        r_c_data <= req0_data;
      end else if (w_gnt1) begin
        r_rr     <= 1'b0;
        r_c_addr <= req1_addr;
        r_c_data <= req1_data;
      end
    end
  end

  assign w_wr_ok   = r_c_valid && (r_c_addr < LP_NUM_REGS);
  assign w_wr_bad  = r_c_valid && !(r_c_addr < LP_NUM_REGS);
  assign w_duty_wr = w_wr_ok && (r_c_addr == LP_DUTY_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_bank[i] <= '0;
      r_err    <= '0;
      r_strobe <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr_ok && (r_c_addr == 7'(i))) r_bank[i] <= r_c_data;
      end
      if (w_wr_bad && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
      r_strobe <= w_wr_ok;
    end
  end

  generate
    if (SHADOW_DUTY) begin : g_shadow
      logic [7:0] r_shadow;
      // A duty commit landing on frame_sync bypasses the shadow wait and applies at once.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_shadow  <= '0;
          r_duty    <= '0;
          r_pending <= 1'b0;
        end else if (w_duty_wr) begin
          r_shadow <= r_c_data;
          if (frame_sync) begin
            r_duty    <= r_c_data;
            r_pending <= 1'b0;
          end else begin
            r_pending <= 1'b1;
          end
        end else if (frame_sync && r_pending) begin
          r_duty    <= r_shadow;
          r_pending <= 1'b0;
        end
      end
    end else begin : g_direct
      always_ff @(posedge clk) begin
        if (rst) begin
          r_duty <= '0;
        end else if (w_duty_wr) begin
          r_duty <= r_c_data;
        end
        r_pending <= 1'b0;
      end
    end
  endgenerate

  assign en_reg_out_7_0  = r_bank[0];
  assign en_reg_out_15_8 = r_bank[1];
  assign en_reg_pwm_7_0  = r_bank[2];
  assign en_reg_pwm_15_8 = r_bank[3];
  assign pwm_duty_cycle  = r_duty;
  assign duty_pending    = r_pending;
  assign err_count       = r_err;
  assign wr_strobe       = r_strobe;

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Directed bench for pwm_cfg_arbiter: reset, arbitration order, commit latency,
// shadowed duty timing and err_count saturation, all with hand-computed expectations.
module tb_pwm_cfg_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [6:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;
  logic       frame_sync;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle, err_count;
  logic       duty_pending, wr_strobe;

  int n_checks = 0;
  int n_pass   = 0;
  int strobes;

  always #5 clk = ~clk;

  pwm_cfg_arbiter #(.NUM_REGS(5), .SHADOW_DUTY(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .frame_sync(frame_sync),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .duty_pending(duty_pending),
    .err_count(err_count), .wr_strobe(wr_strobe)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v) begin
      n_pass++;
      $display("check %s: got %0h", tag, obs);
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out0"}, {8'h0, en_reg_out_7_0}, 16'h0);
    chk({tag, "_out1"}, {8'h0, en_reg_out_15_8}, 16'h0);
    chk({tag, "_pwm0"}, {8'h0, en_reg_pwm_7_0}, 16'h0);
    chk({tag, "_pwm1"}, {8'h0, en_reg_pwm_15_8}, 16'h0);
    chk({tag, "_duty"}, {8'h0, pwm_duty_cycle}, 16'h0);
    chk({tag, "_misc"}, {5'h0, duty_pending, wr_strobe, 1'b0, err_count}, 16'h0);
  endtask

  initial begin
    rst = 1'b1; frame_sync = 1'b0;
    req0_valid = 1'b1; req0_addr = 7'h00; req0_data = 8'h55;
    req1_valid = 1'b0; req1_addr = 7'h00; req1_data = 8'h00;

    // Reset with a pending request: no ready, everything cleared.
    tick();
    chk("rst_ready", {14'h0, req0_ready, req1_ready}, 16'h0);
    tick();
    chk_all_zero("rst");
    req0_valid = 1'b0; rst = 1'b0;
    tick();
    chk("rst_release_out0", {8'h0, en_reg_out_7_0}, 16'h0);

    // Latency: req1 handshake at edge N, bank updated at N+1, strobe one cycle.
    req1_valid = 1'b1; req1_addr = 7'h01; req1_data = 8'hA5;
    #1;
    chk("lat_ready", {14'h0, req0_ready, req1_ready}, 16'h1);
    tick();
    req1_valid = 1'b0;
    chk("lat_n0", {7'h0, wr_strobe, en_reg_out_15_8}, 16'h000);
    tick();
    chk("lat_n1", {7'h0, wr_strobe, en_reg_out_15_8}, 16'h1A5);
    tick();
    chk("lat_n2", {7'h0, wr_strobe, en_reg_out_15_8}, 16'h0A5);

    // Arbitration: both valid, grants must alternate starting with req0.
    strobes = 0;
    req0_valid = 1'b1; req0_addr = 7'h00; req0_data = 8'h11;
    req1_valid = 1'b1; req1_addr = 7'h02; req1_data = 8'h33;
    #1;
    chk("arb_g1", {14'h0, req0_ready, req1_ready}, 16'h2);
    tick(); strobes += int'(wr_strobe);
    req0_addr = 7'h01; req0_data = 8'h22;
    #1;
    chk("arb_g2", {14'h0, req0_ready, req1_ready}, 16'h1);
    tick(); strobes += int'(wr_strobe);
    req1_addr = 7'h03; req1_data = 8'h44;
    #1;
    chk("arb_g3", {14'h0, req0_ready, req1_ready}, 16'h2);
    tick(); strobes += int'(wr_strobe);
    req0_valid = 1'b0;
    #1;
    chk("arb_g4", {14'h0, req0_ready, req1_ready}, 16'h1);
    tick(); strobes += int'(wr_strobe);
    req1_valid = 1'b0;
    tick(); strobes += int'(wr_strobe);
    tick(); strobes += int'(wr_strobe);
    chk("arb_strobes", 16'(strobes), 16'd4);
    chk("arb_out", {en_reg_out_15_8, en_reg_out_7_0}, 16'h2211);
    chk("arb_pwm", {en_reg_pwm_15_8, en_reg_pwm_7_0}, 16'h4433);

    // Shadow duty: two writes before a frame, only the last one is applied.
    req0_valid = 1'b1; req0_addr = 7'h04; req0_data = 8'h80;
    tick();
    req0_data = 8'hC0;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("sh_hold", {7'h0, duty_pending, pwm_duty_cycle}, 16'h100);
    tick();
    chk("sh_hold2", {7'h0, duty_pending, pwm_duty_cycle}, 16'h100);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    chk("sh_apply", {7'h0, duty_pending, pwm_duty_cycle}, 16'h0C0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    chk("sh_idle_frame", {7'h0, duty_pending, pwm_duty_cycle}, 16'h0C0);
    req0_valid = 1'b1; req0_data = 8'h10;
    tick();
    req0_valid = 1'b0; frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    chk("sh_coincident", {7'h0, duty_pending, pwm_duty_cycle}, 16'h010);

    // Bad addresses: 258 back-to-back rejects, counter saturates, bank untouched.
    strobes = 0;
    for (int i = 0; i < 258; i++) begin
      req0_valid = 1'b1;
      req0_addr  = (i % 2 == 1) ? 7'h7F : 7'h05;
      req0_data  = 8'(i);
      tick(); strobes += int'(wr_strobe);
      if (i == 10) chk("err_mid", {8'h0, err_count}, 16'd10);
    end
    req0_valid = 1'b0;
    tick(); strobes += int'(wr_strobe);
    tick(); strobes += int'(wr_strobe);
    chk("err_sat", {8'h0, err_count}, 16'hFF);
    chk("err_strobes", 16'(strobes), 16'd0);
    chk("err_regs", {en_reg_out_7_0, pwm_duty_cycle}, 16'h1110);

    // Mid-stream reset discards the command already in the commit stage.
    req0_valid = 1'b1; req0_addr = 7'h00; req0_data = 8'h77;
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_ready", {14'h0, req0_ready, req1_ready}, 16'h0);
    tick();
    chk_all_zero("mrst1");
    chk("mrst_ready2", {14'h0, req0_ready, req1_ready}, 16'h0);
    tick();
    chk_all_zero("mrst2");
    rst = 1'b0; req0_valid = 1'b0;
    tick();
    chk("mrst_after1", {7'h0, wr_strobe, en_reg_out_7_0}, 16'h0);
    tick();
    chk("mrst_after2", {7'h0, wr_strobe, en_reg_out_7_0}, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
